// File: rtl/pin_sample_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : pin_sample_collector_if
// Brief    : Register-bus and host-FIFO signal bundle for pin_sample_collector.
// Revision : 1.0  initial release
// ============================================================================
interface pin_sample_collector_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int c_LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [18:0]        bus_addr;
    logic               bus_rd;
    logic [15:0]        bus_data;
    logic               fifo_rd;
    logic [15:0]        fifo_data;
    logic               fifo_empty;
    logic               fifo_full;
    logic [c_LVL_W-1:0] fifo_level;

    modport master (
        output bus_addr, bus_rd,
        input  bus_data,
        input  fifo_rd,
        output fifo_data, fifo_empty, fifo_full, fifo_level
    );

    modport slave (
        input  bus_addr, bus_rd,
        output bus_data,
        output fifo_rd,
        input  fifo_data, fifo_empty, fifo_full, fifo_level
    );
endinterface
`default_nettype wire

// File: rtl/pin_sample_collector.sv
`default_nettype none
// ============================================================================
// Module   : pin_sample_collector
// Brief    : Round-robin poller of pin-controller sample counters; changed
//            samples are tagged and queued in a FWFT FIFO for the host.
//            Optional macro COLLECTOR_MISSED_DETECT_EN flags skipped samples.
// Revision : 1.0  initial release
// ============================================================================
module pin_sample_collector #(
    parameter int NUM_PINS   = 8,
    parameter int BASE_POS   = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               enable,
    input  wire logic               clr_status,
    pin_sample_collector_if.master  bus,
    output logic                    overflow
);
    localparam int c_IDX_W = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1;
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    localparam logic [2:0] c_S_IDLE      = 3'd0;
    localparam logic [2:0] c_S_RD_CNT    = 3'd1;
    localparam logic [2:0] c_S_CHECK     = 3'd2;
    localparam logic [2:0] c_S_RD_SAMPLE = 3'd3;
    localparam logic [2:0] c_S_NEXT      = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [c_IDX_W-1:0] r_idx;
    logic [15:0]        r_cnt_q;
    logic [15:0]        r_last_cnt [NUM_PINS];
    logic               r_overflow;

    logic [15:0]        r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;

    logic [10:0]        w_pos;
    logic               w_changed;
    logic               w_missed;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_ovf_set;

    assign w_pos     = 11'(BASE_POS) + 11'(r_idx);
    assign w_changed = (r_cnt_q != r_last_cnt[r_idx]);
    assign w_full    = (r_level == c_LVL_W'(FIFO_DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_push    = (r_state == c_S_RD_SAMPLE) && !w_full;
    assign w_pop     = bus.fifo_rd && !w_empty;

`ifdef COLLECTOR_MISSED_DETECT_EN
    logic [15:0] w_delta;
    // Modular difference: a wrap from 0xFFFF to 0x0000 is a single step.
    assign w_delta  = r_cnt_q - r_last_cnt[r_idx];
    assign w_missed = (w_delta > 16'd1);
`else
    assign w_missed = 1'b0;
`endif

    assign w_ovf_set = (r_state == c_S_CHECK) && w_changed && (w_full || w_missed);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE:      w_state_next = enable ? c_S_RD_CNT : c_S_IDLE;
            c_S_RD_CNT:    w_state_next = c_S_CHECK;
            c_S_CHECK: begin
                if (!w_changed || w_full) w_state_next = c_S_NEXT;
                else                      w_state_next = c_S_RD_SAMPLE;
            end
            c_S_RD_SAMPLE: w_state_next = c_S_NEXT;
            c_S_NEXT:      w_state_next = enable ? c_S_RD_CNT : c_S_IDLE;
            default:       w_state_next = c_S_IDLE;
        endcase
    end

    // Bus outputs, decoded from state only
    always_comb begin
        bus.bus_rd   = 1'b0;
        bus.bus_addr = 19'h0;
        case (r_state)
            c_S_RD_CNT: begin
                bus.bus_rd   = 1'b1;
                bus.bus_addr = {w_pos, 8'h08};
            end
            c_S_RD_SAMPLE: begin
                bus.bus_rd   = 1'b1;
                bus.bus_addr = {w_pos, 8'h07};
            end
            default: begin
                bus.bus_rd   = 1'b0;
                bus.bus_addr = 19'h0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx      <= '0;
            r_cnt_q    <= 16'h0;
            r_overflow <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            for (int i = 0; i < NUM_PINS; i++) begin
                r_last_cnt[i] <= 16'h0;
            end
        end else begin
            if (r_state == c_S_RD_CNT) begin
                r_cnt_q <= bus.bus_data;
            end
            if ((r_state == c_S_CHECK) && w_changed) begin
                r_last_cnt[r_idx] <= r_cnt_q;
            end
            if (r_state == c_S_NEXT) begin
                r_idx <= (r_idx == c_IDX_W'(NUM_PINS - 1)) ? '0 : r_idx + 1'b1;
            end
            // A set wins over a simultaneous clear.
            r_overflow <= w_ovf_set | (r_overflow & ~clr_status);

            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_pos[7:0], r_cnt_q[6:0], bus.bus_data[0]};
        end
    end

    assign bus.fifo_data  = w_empty ? 16'h0 : r_mem[r_rd_ptr];
    assign bus.fifo_empty = w_empty;
    assign bus.fifo_full  = w_full;
    assign bus.fifo_level = r_level;
    assign overflow       = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pin_sample_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_pin_sample_collector
// Brief    : Scoreboard bench for pin_sample_collector with a pin-array model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pin_sample_collector;
    localparam int NUM_PINS   = 8;
    localparam int FIFO_DEPTH = 4;
`ifdef COLLECTOR_MISSED_DETECT_EN
    localparam logic c_MISSED = 1'b1;
`else
    localparam logic c_MISSED = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic clr_status = 1'b0;
    logic overflow;

    always #5 clk = ~clk;

    pin_sample_collector_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus_if ();

    pin_sample_collector #(
        .NUM_PINS   (NUM_PINS),
        .BASE_POS   (0),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .clr_status (clr_status),
        .bus        (bus_if),
        .overflow   (overflow)
    );

    logic [15:0] pin_cnt [NUM_PINS];
    logic        pin_bit [NUM_PINS];
    logic [10:0] m_pos;

    // Pin-controller array: combinational read data, zero when not addressed.
    always_comb begin
        bus_if.bus_data = 16'h0;
        m_pos = bus_if.bus_addr[18:8];
        if (bus_if.bus_rd && (m_pos < 11'(NUM_PINS))) begin
            if (bus_if.bus_addr[7:0] == 8'h08)
                bus_if.bus_data = pin_cnt[m_pos[2:0]];
            else if (bus_if.bus_addr[7:0] == 8'h07)
                bus_if.bus_data = {15'h0, pin_bit[m_pos[2:0]]};
        end
    end

    logic [15:0] exp_q [$];
    logic        drain_en = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops every presented entry while draining is enabled.
    initial begin
        bus_if.fifo_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (drain_en && !bus_if.fifo_empty) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_entry: got 0x%0h, expected no entry", bus_if.fifo_data);
                end else begin
                    check("fifo_entry", 32'(bus_if.fifo_data), 32'(exp_q.pop_front()));
                end
                bus_if.fifo_rd = 1'b1;
            end else begin
                bus_if.fifo_rd = 1'b0;
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || !bus_if.fifo_empty) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check({name, "_drain_in_time"}, 32'(k < 300), 32'd1);
    endtask

    task automatic wait_level(input string name, input int lvl);
        int k = 0;
        while (bus_if.fifo_level != 3'(lvl) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({name, "_level"}, 32'(bus_if.fifo_level), 32'(lvl));
    endtask

    task automatic wait_addr(input string name, input logic [18:0] a);
        int k = 0;
        while (!(bus_if.bus_rd && bus_if.bus_addr == a) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({name, "_reached"}, 32'(k < 200), 32'd1);
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ovf_pins [4] = '{0, 3, 4, 7};
        logic [19:0] e;
        int k;

        for (int i = 0; i < NUM_PINS; i++) begin
            pin_cnt[i] = 16'h0;
            pin_bit[i] = 1'b0;
        end
        enable = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_empty",    32'(bus_if.fifo_empty), 32'd1);
        check("rst_full",     32'(bus_if.fifo_full),  32'd0);
        check("rst_level",    32'(bus_if.fifo_level), 32'd0);
        check("rst_data",     32'(bus_if.fifo_data),  32'd0);
        check("rst_bus",      32'({bus_if.bus_rd, bus_if.bus_addr}), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // Idle scan: count reads every third cycle, bus quiet otherwise.
        reset = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            e = (i % 3 == 0) ? {1'b1, 3'b000, 8'(i / 3), 8'h08} : 20'h0;
            check("scan_bus", 32'({bus_if.bus_rd, bus_if.bus_addr}), 32'(e));
        end
        check("scan_empty", 32'(bus_if.fifo_empty), 32'd1);

        // Single change on pin 2.
        pin_bit[2] = 1'b1;
        pin_cnt[2] = 16'h0001;
        exp_q.push_back(16'h0203);
        wait_level("pin2", 1);
        drain_en = 1'b1;
        wait_drain("pin2");
        wait_cycles(40);
        check("pin2_no_repush", 32'(bus_if.fifo_empty), 32'd1);
        check("empty_data_zero", 32'(bus_if.fifo_data), 32'd0);

        // Pin 5 to 0xFFFF, then wrap to 0x0000.
        pin_bit[5] = 1'b0;
        pin_cnt[5] = 16'hFFFF;
        exp_q.push_back(16'h05FE);
        wait_drain("pin5_ffff");
        check("pin5_ffff_overflow", 32'(overflow), 32'(c_MISSED));
        pulse_clr();
        check("pin5_clr", 32'(overflow), 32'd0);
        pin_bit[5] = 1'b1;
        pin_cnt[5] = 16'h0000;
        exp_q.push_back(16'h0501);
        wait_drain("pin5_wrap");
        check("pin5_wrap_overflow", 32'(overflow), 32'd0);

        // Fill the FIFO, then one more change is refused.
        drain_en = 1'b0;
        for (int j = 0; j < 4; j++) begin
            pin_bit[ovf_pins[j]] = 1'b0;
            pin_cnt[ovf_pins[j]] = 16'h0001;
            exp_q.push_back({8'(ovf_pins[j]), 8'h02});
            wait_level("ovf_fill", j + 1);
        end
        check("ovf_full", 32'(bus_if.fifo_full), 32'd1);
        check("ovf_before", 32'(overflow), 32'd0);
        pin_cnt[6] = 16'h0001;
        k = 0;
        while (!overflow && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_level", 32'(bus_if.fifo_level), 32'd4);
        wait_cycles(40);
        check("ovf_level_held", 32'(bus_if.fifo_level), 32'd4);
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("ovf_head", 32'(bus_if.fifo_data), 32'h0002);
        pulse_clr();
        check("ovf_clr", 32'(overflow), 32'd0);
        drain_en = 1'b1;
        wait_drain("ovf");
        wait_cycles(80);
        check("ovf_no_repush", 32'(bus_if.fifo_empty), 32'd1);
        check("ovf_stays_clear", 32'(overflow), 32'd0);

        // Pin 1 single steps, then a jump of three.
        for (int v = 1; v <= 3; v++) begin
            pin_bit[1] = 1'b0;
            pin_cnt[1] = 16'(v);
            exp_q.push_back({8'h01, 7'(v), 1'b0});
            wait_drain("pin1_step");
        end
        check("pin1_step_overflow", 32'(overflow), 32'd0);
        pin_bit[1] = 1'b1;
        pin_cnt[1] = 16'h0006;
        exp_q.push_back(16'h010D);
        wait_drain("pin1_jump");
        check("pin1_jump_overflow", 32'(overflow), 32'(c_MISSED));
        pulse_clr();

        // Drop enable while pin 3's count is being read.
        wait_addr("pin3_rdcnt", 19'h00308);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("enable_drop_bus", 32'({bus_if.bus_rd, bus_if.bus_addr}), 32'd0);
        end
        enable = 1'b1;
        @(negedge clk);
        check("resume_idx4", 32'({bus_if.bus_rd, bus_if.bus_addr}), 32'({1'b1, 19'h00408}));

        // Reset while pin 2's sample is being read.
        drain_en = 1'b0;
        pin_bit[2] = 1'b0;
        pin_cnt[2] = 16'h0002;
        wait_addr("pin2_rdsample", 19'h00207);
        reset = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        check("rst_mid_empty", 32'(bus_if.fifo_empty), 32'd1);
        check("rst_mid_level", 32'(bus_if.fifo_level), 32'd0);
        check("rst_mid_bus_rd", 32'(bus_if.bus_rd), 32'd0);
        check("rst_mid_data", 32'(bus_if.fifo_data), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        reset = 1'b0;
        wait_cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
